mux32_serializer: RTL and testbench
===================================

Name: mux32_serializer

Overview:
- Parallel-to-serial stage that feeds the `mux32` select path.
- Captures a 32-bit word through a valid/ready handshake into a holding register. A bit counter drives the `ena` select of an internal `mux32` instance, so the word streams out one bit per accepted beat, LSB first.
- Sits between a word producer (register file or bus) and a 1-bit serial consumer.

Parameters:
- WIDTH, 32, word width. Must be a power of two, 2..32.
- SEL_W, $clog2(WIDTH), counter and select width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  parallel word from upstream.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  serial bit, equal to the internal `mux32` out for the held word at select = count.
- out_valid  output  1  out_bit valid.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_last  output  1  current beat is the final beat of the word.
- busy  output  1  a word is held (state SHIFT).

Behaviour:
- Reset (rst_n low, async, overrides all):
  - state=IDLE, holding register=0, count=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_bit=0.
  - Release takes effect at the first clk edge with rst_n high.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: hold<=in_data, count<=0, go to SHIFT.
  - Latency: the first bit is valid in the cycle after acceptance.
- SHIFT:
  - out_valid=1; out_bit=hold[count], produced through the `mux32` instance with ena=count.
  - A beat completes on out_valid&&out_ready. Then count<=count+1.
  - Without a beat, count, out_bit and out_last are held stable (no bit dropped or repeated).
- out_last: 1 only when count==WIDTH-1 (or the parity beat, see Optional Feature).
- Last beat accepted:
  - count wraps to 0.
  - If in_valid is also high that cycle: the new word loads, state stays SHIFT, giving back-to-back words with zero bubble.
  - Otherwise: go to IDLE.
- in_ready:
  - 1 in IDLE.
  - In SHIFT, 1 only in a cycle where the last beat is accepted (out_last&&out_ready). This is a combinational out_ready->in_ready path by design.
- in_valid without in_ready: ignored. in_data is sampled only on the handshake.
- Counter arithmetic: SEL_W bits, unsigned, natural wrap at WIDTH. The counter never takes values ≥WIDTH.
- Async reset mid-word: the word is discarded, with no partial completion and no out_last.
- No X propagation: out_bit is driven 0 in IDLE.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After data bit WIDTH-1, one extra beat carries even parity (XOR of all held bits).
  - The parity beat uses a 1-bit phase flag; the counter does not extend.
  - out_last moves to the parity beat. The word takes WIDTH+1 beats.
  - in_ready back-to-back rule applies on the parity beat.
- Undefined: exactly WIDTH beats; no parity logic synthesized.

Test Plan:
- Reset then load 32'h8000_0001 with out_ready=1 → out_bit sequence 1, then 30×0, then 1; out_last high only on beat 31; busy falls the cycle after.
- Load 32'hA5A5_A5A5, toggle out_ready 1/0 every cycle → 32 accepted beats with bits 1,0,1,0,0,1,0,1,…; out_bit and out_last stable during stall cycles.
- Two words back-to-back (32'hFFFF_FFFF then 32'h0000_0000), in_valid held high → 64 consecutive valid beats, no gap; in_ready pulses only on beat 31.
- Assert rst_n=0 mid-word at beat 10 → out_valid/busy drop immediately (asynchronously); after release, a new word 32'h0000_0003 serializes from bit 0.
- in_valid pulsed while SHIFT and not last beat → in_ready=0; word ignored; held word completes unchanged.
- With SERIALIZER_PARITY_EN, word 32'h0000_0007 → 33 beats; beat 32 = 1 with out_last; word 32'h0000_0003 → parity beat = 0.

Source files
------------

// File: rtl/mux32_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mux32_serializer (with helper mux32)
// Purpose  : Parallel-to-serial stage; streams a held word LSB first via mux32.
//            Define SERIALIZER_PARITY_EN to append an even-parity beat per word.
// Revision : 1.0  initial release
// ============================================================================

module mux32 #(
   parameter int WIDTH = 32,
   localparam int SEL_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in,
   input  logic [SEL_W-1:0] ena,
   output logic             out
);

   assign out = in[ena];

endmodule

module mux32_serializer #(
   parameter int WIDTH = 32,
   localparam int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_hold;
   logic [SEL_W-1:0] r_count;

   logic w_mux_bit;
   logic w_bit;
   logic w_last;
   logic w_beat;
   logic w_load;

   mux32 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .in  (r_hold),
      .ena (r_count),
      .out (w_mux_bit)
   );

`ifdef SERIALIZER_PARITY_EN
   // Phase flag marks the extra parity beat; the counter has already wrapped to 0.
   logic r_phase;

   assign w_last = (r_state == SHIFT) && r_phase;
   assign w_bit  = r_phase ? (^r_hold) : w_mux_bit;
`else
   assign w_last = (r_state == SHIFT) && (r_count == c_last_sel);
   assign w_bit  = w_mux_bit;
`endif

   assign w_beat = (r_state == SHIFT) && out_ready;

   // Ready reopens combinationally on the accepted last beat for zero-bubble reload.
   assign in_ready = (r_state == IDLE) || (w_last && out_ready);
   assign w_load   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_count <= '0;
`ifdef SERIALIZER_PARITY_EN
         r_phase <= 1'b0;
`endif
      end else if (w_load) begin
         r_state <= SHIFT;
         r_hold  <= in_data;
         r_count <= '0;
`ifdef SERIALIZER_PARITY_EN
         r_phase <= 1'b0;
`endif
      end else if (w_beat) begin
         if (w_last) begin
            r_state <= IDLE;
            r_count <= '0;
`ifdef SERIALIZER_PARITY_EN
            r_phase <= 1'b0;
`endif
         end else begin
            r_count <= r_count + SEL_W'(1);
`ifdef SERIALIZER_PARITY_EN
            if (r_count == c_last_sel) begin
               r_phase <= 1'b1;
            end
`endif
         end
      end
   end

   assign out_valid = (r_state == SHIFT);
   assign busy      = (r_state == SHIFT);
   assign out_last  = w_last;
   assign out_bit   = (r_state == SHIFT) && w_bit;

endmodule

`default_nettype wire

// File: tb/tb_mux32_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux32_serializer
// Purpose  : Self-checking bench: vector table, directed corners, random traffic
//            against a queue-of-expected-bits reference model.
// Revision : 1.0  initial release
// ============================================================================

module tb_mux32_serializer;

   localparam int WIDTH = 32;
`ifdef SERIALIZER_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_bit;
   logic        out_valid;
   logic        out_last;
   logic        busy;

   int   checks = 0;
   int   failures = 0;
   int   vcount = 0;
   logic last_seen_bit = 1'b0;
   bit   q[$];

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        e_rdy;
      logic        e_val;
      logic        e_bit;
      logic        e_last;
      logic        e_busy;
   } vec_t;

   vec_t tbl[NB + 2];

   mux32_serializer #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_word(input logic [31:0] d);
      for (int i = 0; i < WIDTH; i++) q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
      q.push_back(^d);
`endif
   endfunction

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
      logic exp_rdy;
      int   n;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
      n = q.size();
      exp_rdy = (n == 0) || (n == 1 && ordy);
      chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, n != 0});
      chk("busy",      {31'd0, busy},      {31'd0, n != 0});
      chk("out_bit",   {31'd0, out_bit},   {31'd0, (n != 0) ? q[0] : 1'b0});
      chk("out_last",  {31'd0, out_last},  {31'd0, n == 1});
      if (out_valid) vcount++;
      if (out_valid && out_last && ordy) last_seen_bit = out_bit;
      @(posedge clk);
      if (n != 0 && ordy) void'(q.pop_front());
      if (iv && exp_rdy) push_word(d);
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() != 0 && g < NB * 4) begin
         step(1'b0, 32'd0, 1'b1);
         g++;
      end
      chk("drain_timeout", q.size(), 32'd0);
   endtask

   initial begin
      logic b;
      logic iv;
      logic ordy;
      int   i;

      // Table: load 8000_0001 with out_ready held high.
      tbl[0] = '{iv: 1'b1, d: 32'h8000_0001, ordy: 1'b1,
                 e_rdy: 1'b1, e_val: 1'b0, e_bit: 1'b0, e_last: 1'b0, e_busy: 1'b0};
      for (int k = 0; k < NB; k++) begin
         b = (k == 0) || (k == WIDTH - 1);
         tbl[k + 1] = '{iv: 1'b0, d: 32'd0, ordy: 1'b1,
                        e_rdy: (k == NB - 1), e_val: 1'b1, e_bit: b,
                        e_last: (k == NB - 1), e_busy: 1'b1};
      end
      tbl[NB + 1] = '{iv: 1'b0, d: 32'd0, ordy: 1'b1,
                      e_rdy: 1'b1, e_val: 1'b0, e_bit: 1'b0, e_last: 1'b0, e_busy: 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_out_bit",   {31'd0, out_bit},   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < NB + 2; v++) begin
         @(negedge clk);
         in_valid  = tbl[v].iv;
         in_data   = tbl[v].d;
         out_ready = tbl[v].ordy;
         #1;
         chk($sformatf("tbl%0d_rdy", v),  {31'd0, in_ready},  {31'd0, tbl[v].e_rdy});
         chk($sformatf("tbl%0d_val", v),  {31'd0, out_valid}, {31'd0, tbl[v].e_val});
         chk($sformatf("tbl%0d_bit", v),  {31'd0, out_bit},   {31'd0, tbl[v].e_bit});
         chk($sformatf("tbl%0d_last", v), {31'd0, out_last},  {31'd0, tbl[v].e_last});
         chk($sformatf("tbl%0d_busy", v), {31'd0, busy},      {31'd0, tbl[v].e_busy});
         @(posedge clk);
      end

      // Stalls every other cycle
      step(1'b1, 32'hA5A5_A5A5, 1'b1);
      i = 1;
      while (q.size() != 0 && i < 200) begin
         step(1'b0, 32'd0, i[0]);
         i++;
      end
      chk("stall_timeout", q.size(), 32'd0);

      // Back-to-back words with no bubble
      vcount = 0;
      for (int k = 0; k <= 2 * NB; k++) begin
         step((k == 0) || (k == NB), (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1);
      end
      chk("b2b_beats", vcount, 2 * NB);

      // Word offered mid-shift must be ignored
      step(1'b1, 32'h1234_5678, 1'b1);
      repeat (5) step(1'b0, 32'd0, 1'b1);
      step(1'b1, 32'hDEAD_BEEF, 1'b1);
      drain();

      // Final-beat value: parity beat when enabled, else data bit WIDTH-1
      step(1'b1, 32'h0000_0007, 1'b1);
      drain();
`ifdef SERIALIZER_PARITY_EN
      chk("last_bit_w7", {31'd0, last_seen_bit}, 32'd1);
`else
      chk("last_bit_w7", {31'd0, last_seen_bit}, 32'd0);
`endif
      step(1'b1, 32'h0000_0003, 1'b1);
      drain();
      chk("last_bit_w3", {31'd0, last_seen_bit}, 32'd0);

      // Async reset mid-word at beat 10
      step(1'b1, 32'hFFFF_FFFF, 1'b1);
      repeat (10) step(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_busy",      {31'd0, busy},      32'd0);
      chk("arst_out_last",  {31'd0, out_last},  32'd0);
      chk("arst_out_bit",   {31'd0, out_bit},   32'd0);
      chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'h0000_0003, 1'b1);
      drain();

      // Random traffic
      for (int k = 0; k < 800; k++) begin
         iv   = ($urandom_range(0, 1) == 1);
         ordy = ($urandom_range(0, 3) != 0);
         step(iv, $urandom, ordy);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
